// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, the
// memory-watchdog state type and the load-use hazard predicate.
package pipe_ctrl_pkg;

  // One bit per stage register; STOP holds that stage.
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_LOAD_USE = 6'b000111;  // bubble into ID/EXE
  localparam logic [5:0] STALL_EXE      = 6'b001111;  // ID/EXE holds too
  localparam logic [5:0] STALL_MEM      = 6'b011111;  // EXE/MEM holds too

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_ABORT
  } mem_state_e;

  // A load in EXE whose destination is read by the instruction in ID.
  // x0 is never a real dependency.
  function automatic logic load_use_hazard(input logic       is_load,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic       rs1_re,
                                           input logic [4:0] rs2,
                                           input logic       rs2_re);
    return is_load && (rd != ZERO_REG) &&
           ((rs1_re && (rs1 == rd)) || (rs2_re && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline stages and pipe_ctrl.
//   master : pipeline side (drives hazard/divide/memory/jump status)
//   slave  : pipe_ctrl side (drives stall vector, flush, redirect, counters)
interface pipe_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           id_rs1_i;
  logic [4:0]           id_rs2_i;
  logic                 id_rs1_re_i;
  logic                 id_rs2_re_i;
  logic                 ex_is_load_i;
  logic [4:0]           ex_rd_i;
  logic                 ex_div_start_i;
  logic                 div_ready_i;
  logic                 mem_req_i;
  logic                 mem_ack_i;
  logic                 jump_i;
  logic [31:0]          jump_addr_i;
  logic [5:0]           stall_o;
  logic                 flush_jump_o;
  logic [31:0]          jump_addr_o;
  logic                 bus_err_o;
  logic [CNT_WIDTH-1:0] stall_cnt_o;
  logic [CNT_WIDTH-1:0] flush_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
           ex_is_load_i, ex_rd_i, ex_div_start_i, div_ready_i,
           mem_req_i, mem_ack_i, jump_i, jump_addr_i,
    input  stall_o, flush_jump_o, jump_addr_o, bus_err_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
           ex_is_load_i, ex_rd_i, ex_div_start_i, div_ready_i,
           mem_req_i, mem_ack_i, jump_i, jump_addr_i,
    output stall_o, flush_jump_o, jump_addr_o, bus_err_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_mem_wd.sv
// Memory-wait sequencer with watchdog.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   mem_req_i      : MEM stage has an outstanding bus access
//   mem_ack_i      : bus acknowledges this cycle
//   mem_stall_o    : hold the pipeline up to and including EXE/MEM
//   bus_err_o      : one-cycle pulse when the access is abandoned
// A request stalls for at most MEM_TIMEOUT-1 cycles; the next cycle is the
// abort cycle, which releases the stall and flags the error.
module pipe_ctrl_mem_wd
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_req_i,
  input  logic mem_ack_i,
  output logic mem_stall_o,
  output logic bus_err_o
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  always_ff @(posedge clk_i) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    if (rst_i) begin
      state_q <= MEM_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_stall_o = 1'b0;
    bus_err_o   = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        // The first wait cycle stalls straight from the inputs, so a
        // zero-wait ack never stalls.
        if (mem_req_i && !mem_ack_i) begin
          mem_stall_o = 1'b1;
          wcnt_d      = WCNT_ONE;
          state_d     = (WCNT_ONE == WCNT_LAST) ? MEM_ABORT : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d = MEM_IDLE;
          wcnt_d  = '0;
        end else begin
          mem_stall_o = 1'b1;
          wcnt_d      = wcnt_q + WCNT_ONE;
          if (wcnt_q + WCNT_ONE == WCNT_LAST) state_d = MEM_ABORT;
        end
      end
      MEM_ABORT: begin
        bus_err_o = 1'b1;
        wcnt_d    = '0;
        state_d   = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage core.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : hazard/divide/memory/jump status in; stall vector,
//                  jump flush, PC redirect, bus error and performance
//                  counters out
// Stall priority: memory wait, then divide, then load-use. A jump flushes
// whenever EXE is not held (stall bit 3 clear).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  pipe_ctrl_if.slave  bus
);

  logic                 mem_stall;
  logic                 mem_bus_err;
  logic                 hazard;
  logic                 div_stall;
  logic                 div_busy_q;
  logic [5:0]           stall;
  logic                 flush;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  pipe_ctrl_mem_wd #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wd (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mem_req_i   (bus.mem_req_i),
    .mem_ack_i   (bus.mem_ack_i),
    .mem_stall_o (mem_stall),
    .bus_err_o   (mem_bus_err)
  );

  assign hazard = load_use_hazard(bus.ex_is_load_i, bus.ex_rd_i,
                                  bus.id_rs1_i, bus.id_rs1_re_i,
                                  bus.id_rs2_i, bus.id_rs2_re_i);

  // div_busy covers cycles where EXE no longer presents the start flag but
  // the divider has not delivered; the ready cycle itself never stalls.
  assign div_stall = (bus.ex_div_start_i || div_busy_q) && !bus.div_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i)                  div_busy_q <= 1'b0;
    else if (bus.div_ready_i)   div_busy_q <= 1'b0;
    else if (bus.ex_div_start_i) div_busy_q <= 1'b1;
  end

  // Outputs are forced quiet while reset is held so the rest of the core
  // sees the reset values in the reset cycle itself. A jump beats a
  // load-use hazard: the jump squashes the dependent instruction anyway.
  always_comb begin
    stall = STALL_NONE;
    if (!rst_i) begin
      if (mem_stall)                  stall = STALL_MEM;
      else if (div_stall)             stall = STALL_EXE;
      else if (hazard && !bus.jump_i) stall = STALL_LOAD_USE;
    end
  end

  assign flush = !rst_i && bus.jump_i && (stall[3] == NOSTOP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall[0] == STOP) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (flush)            flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.stall_o      = stall;
  assign bus.flush_jump_o = flush;
  assign bus.jump_addr_o  = flush ? bus.jump_addr_i : 32'd0;
  assign bus.bus_err_o    = mem_bus_err && !rst_i;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Each cycle the stimulus is driven just after
// the rising edge, the expected outputs are pushed to a scoreboard, and at
// the falling edge the entry is popped and compared against the DUT.
module tb_pipe_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  pipe_ctrl_if #(.CNT_WIDTH(32)) bus ();

  pipe_ctrl #(
    .MEM_TIMEOUT (16),
    .CNT_WIDTH   (32)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] jaddr;
    logic        berr;
  } exp_t;

  exp_t sb[$];

  int          passes = 0;
  int          total  = 0;
  logic [31:0] exp_stall_cnt = 32'd0;
  logic [31:0] exp_flush_cnt = 32'd0;

  localparam logic [5:0]  S_NONE = 6'b000000;
  localparam logic [5:0]  S_LU   = 6'b000111;
  localparam logic [5:0]  S_EXE  = 6'b001111;
  localparam logic [5:0]  S_MEM  = 6'b011111;
  localparam logic [31:0] JA     = 32'h8000_0040;
  localparam logic [31:0] JB     = 32'h0000_1234;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    bus.id_rs1_i       = 5'd0;
    bus.id_rs2_i       = 5'd0;
    bus.id_rs1_re_i    = 1'b0;
    bus.id_rs2_re_i    = 1'b0;
    bus.ex_is_load_i   = 1'b0;
    bus.ex_rd_i        = 5'd0;
    bus.ex_div_start_i = 1'b0;
    bus.div_ready_i    = 1'b0;
    bus.mem_req_i      = 1'b0;
    bus.mem_ack_i      = 1'b0;
    bus.jump_i         = 1'b0;
    bus.jump_addr_i    = 32'd0;
  endtask

  // One clock cycle: push expectations, compare at the falling edge, then
  // advance to just after the next rising edge. Counters are registered, so
  // they are compared against the totals of the preceding cycles.
  task automatic expect_cycle(input string tag, input logic [5:0] st,
                              input logic fl, input logic [31:0] ja,
                              input logic be);
    exp_t e;
    sb.push_back('{tag, st, fl, ja, be});
    @(negedge clk_i);
    e = sb.pop_front();
    check({e.tag, ".stall"},     32'(bus.stall_o),      32'(e.stall));
    check({e.tag, ".flush"},     32'(bus.flush_jump_o), 32'(e.flush));
    check({e.tag, ".jaddr"},     bus.jump_addr_o,       e.jaddr);
    check({e.tag, ".bus_err"},   32'(bus.bus_err_o),    32'(e.berr));
    check({e.tag, ".stall_cnt"}, bus.stall_cnt_o,       exp_stall_cnt);
    check({e.tag, ".flush_cnt"}, bus.flush_cnt_o,       exp_flush_cnt);
    if (rst_i) begin
      exp_stall_cnt = 32'd0;
      exp_flush_cnt = 32'd0;
    end else begin
      if (e.stall[0]) exp_stall_cnt = exp_stall_cnt + 32'd1;
      if (e.flush)    exp_flush_cnt = exp_flush_cnt + 32'd1;
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    expect_cycle("reset", S_NONE, 1'b0, 32'd0, 1'b0);
    rst_i = 1'b0;
    expect_cycle("idle", S_NONE, 1'b0, 32'd0, 1'b0);

    // Load-use on rs1, then the bubble clears EXE.
    bus.ex_is_load_i = 1'b1; bus.ex_rd_i = 5'd5;
    bus.id_rs1_i = 5'd5; bus.id_rs1_re_i = 1'b1;
    expect_cycle("lu_rs1", S_LU, 1'b0, 32'd0, 1'b0);
    clear_inputs();
    expect_cycle("lu_rs1_after", S_NONE, 1'b0, 32'd0, 1'b0);

    // Load-use on rs2.
    bus.ex_is_load_i = 1'b1; bus.ex_rd_i = 5'd9;
    bus.id_rs1_i = 5'd3; bus.id_rs1_re_i = 1'b1;
    bus.id_rs2_i = 5'd9; bus.id_rs2_re_i = 1'b1;
    expect_cycle("lu_rs2", S_LU, 1'b0, 32'd0, 1'b0);

    // Matching register that is not read.
    clear_inputs();
    bus.ex_is_load_i = 1'b1; bus.ex_rd_i = 5'd5;
    bus.id_rs1_i = 5'd5; bus.id_rs1_re_i = 1'b0;
    expect_cycle("lu_not_read", S_NONE, 1'b0, 32'd0, 1'b0);

    // Load to x0 is no dependency.
    clear_inputs();
    bus.ex_is_load_i = 1'b1; bus.ex_rd_i = 5'd0;
    bus.id_rs1_i = 5'd0; bus.id_rs1_re_i = 1'b1;
    expect_cycle("lu_x0", S_NONE, 1'b0, 32'd0, 1'b0);

    // Jump together with a load-use: jump wins.
    clear_inputs();
    bus.ex_is_load_i = 1'b1; bus.ex_rd_i = 5'd7;
    bus.id_rs2_i = 5'd7; bus.id_rs2_re_i = 1'b1;
    bus.jump_i = 1'b1; bus.jump_addr_i = JB;
    expect_cycle("jump_vs_lu", S_NONE, 1'b1, JB, 1'b0);
    clear_inputs();
    expect_cycle("jump_after", S_NONE, 1'b0, 32'd0, 1'b0);

    // Divide held 4 cycles, ready on the 5th; one cycle also has a load-use
    // and one a jump, both of which the divide stall must override.
    bus.ex_div_start_i = 1'b1;
    expect_cycle("div_1", S_EXE, 1'b0, 32'd0, 1'b0);
    bus.ex_is_load_i = 1'b1; bus.ex_rd_i = 5'd4;
    bus.id_rs1_i = 5'd4; bus.id_rs1_re_i = 1'b1;
    expect_cycle("div_2_lu", S_EXE, 1'b0, 32'd0, 1'b0);
    bus.ex_is_load_i = 1'b0; bus.id_rs1_re_i = 1'b0;
    bus.jump_i = 1'b1; bus.jump_addr_i = JB;
    expect_cycle("div_3_jump", S_EXE, 1'b0, 32'd0, 1'b0);
    bus.jump_i = 1'b0; bus.jump_addr_i = 32'd0;
    expect_cycle("div_4", S_EXE, 1'b0, 32'd0, 1'b0);
    bus.div_ready_i = 1'b1;
    expect_cycle("div_ready", S_NONE, 1'b0, 32'd0, 1'b0);
    clear_inputs();
    expect_cycle("div_done", S_NONE, 1'b0, 32'd0, 1'b0);

    // Start flag seen for a single cycle: the busy flag keeps the stall.
    bus.ex_div_start_i = 1'b1;
    expect_cycle("divb_start", S_EXE, 1'b0, 32'd0, 1'b0);
    bus.ex_div_start_i = 1'b0;
    expect_cycle("divb_busy", S_EXE, 1'b0, 32'd0, 1'b0);
    bus.div_ready_i = 1'b1;
    expect_cycle("divb_ready", S_NONE, 1'b0, 32'd0, 1'b0);
    clear_inputs();
    expect_cycle("divb_clear", S_NONE, 1'b0, 32'd0, 1'b0);

    // Memory ack on the 3rd cycle; a load-use in the 2nd is outranked.
    bus.mem_req_i = 1'b1;
    expect_cycle("mem_w1", S_MEM, 1'b0, 32'd0, 1'b0);
    bus.ex_is_load_i = 1'b1; bus.ex_rd_i = 5'd6;
    bus.id_rs1_i = 5'd6; bus.id_rs1_re_i = 1'b1;
    expect_cycle("mem_w2_lu", S_MEM, 1'b0, 32'd0, 1'b0);
    bus.ex_is_load_i = 1'b0; bus.id_rs1_re_i = 1'b0;
    bus.mem_ack_i = 1'b1;
    expect_cycle("mem_ack", S_NONE, 1'b0, 32'd0, 1'b0);
    clear_inputs();
    expect_cycle("mem_done", S_NONE, 1'b0, 32'd0, 1'b0);

    // Zero-wait access.
    bus.mem_req_i = 1'b1; bus.mem_ack_i = 1'b1;
    expect_cycle("mem_zero_wait", S_NONE, 1'b0, 32'd0, 1'b0);
    clear_inputs();

    // Never acknowledged: 15 stall cycles, then the abort cycle.
    bus.mem_req_i = 1'b1;
    for (int i = 0; i < 15; i++)
      expect_cycle($sformatf("tmo_wait%0d", i), S_MEM, 1'b0, 32'd0, 1'b0);
    expect_cycle("tmo_abort", S_NONE, 1'b0, 32'd0, 1'b1);
    clear_inputs();
    expect_cycle("tmo_idle", S_NONE, 1'b0, 32'd0, 1'b0);
    bus.mem_req_i = 1'b1; bus.mem_ack_i = 1'b1;
    expect_cycle("tmo_zero_wait", S_NONE, 1'b0, 32'd0, 1'b0);
    clear_inputs();

    // Jump held during a memory stall flushes in the release cycle.
    bus.mem_req_i = 1'b1; bus.jump_i = 1'b1; bus.jump_addr_i = JA;
    expect_cycle("mj_w1", S_MEM, 1'b0, 32'd0, 1'b0);
    expect_cycle("mj_w2", S_MEM, 1'b0, 32'd0, 1'b0);
    bus.mem_ack_i = 1'b1;
    expect_cycle("mj_ack", S_NONE, 1'b1, JA, 1'b0);
    clear_inputs();
    expect_cycle("mj_done", S_NONE, 1'b0, 32'd0, 1'b0);

    // Reset in the middle of a divide.
    bus.ex_div_start_i = 1'b1;
    expect_cycle("rd_div", S_EXE, 1'b0, 32'd0, 1'b0);
    rst_i = 1'b1;
    expect_cycle("rd_reset", S_NONE, 1'b0, 32'd0, 1'b0);
    rst_i = 1'b0;
    clear_inputs();
    expect_cycle("rd_after", S_NONE, 1'b0, 32'd0, 1'b0);

    // Reset in the middle of a memory wait.
    bus.mem_req_i = 1'b1;
    expect_cycle("rw_w1", S_MEM, 1'b0, 32'd0, 1'b0);
    expect_cycle("rw_w2", S_MEM, 1'b0, 32'd0, 1'b0);
    rst_i = 1'b1;
    expect_cycle("rw_reset", S_NONE, 1'b0, 32'd0, 1'b0);
    rst_i = 1'b0;
    clear_inputs();
    expect_cycle("rw_after", S_NONE, 1'b0, 32'd0, 1'b0);
    bus.mem_req_i = 1'b1; bus.mem_ack_i = 1'b1;
    expect_cycle("rw_zero_wait", S_NONE, 1'b0, 32'd0, 1'b0);
    clear_inputs();
    expect_cycle("final_idle", S_NONE, 1'b0, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
